// File: rtl/gain_mul_ctrl.sv
// gain_mul_ctrl: CPU-mapped operand/result window and handshake FSM for an external multiplier.
// Optional macro GAIN_IRQ_EN adds the irq_n output and the CTRL irq_en bit. Rev 1.0
`default_nettype none

module gain_mul_ctrl #(
    parameter logic [15:0] BASE    = 16'h1FF0,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  datao,
    input  logic        we_n,
    output logic [7:0]  rd_data,
    output logic        rd_hit,
    output logic [15:0] data,
    output logic        data_rdy,
    input  logic [15:0] result,
    input  logic        result_rdy
`ifdef GAIN_IRQ_EN
    ,
    output logic        irq_n
`endif
);

    localparam logic [15:0] C_TIMEOUT    = TIMEOUT[15:0];
    localparam logic [15:0] C_OFF_OP_LO  = 16'd0;
    localparam logic [15:0] C_OFF_OP_HI  = 16'd1;
    localparam logic [15:0] C_OFF_CTRL   = 16'd4;
    localparam logic [15:0] C_OFF_STATUS = 16'd5;
    localparam logic [15:0] C_WIN_SIZE   = 16'd6;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] op_q;
    logic [15:0] res_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        done_q;
    logic        timeout_q;
    logic        data_rdy_q;
    logic        irq_en;

    logic [15:0] w_off;
    logic        w_hit;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_start;
    logic        w_abort;
    logic        w_stat_rd;
    logic        w_busy;

    // Offset compare keeps the window decode correct even if BASE sits near the top of the map.
    assign w_off     = addr - BASE;
    assign w_hit     = (w_off < C_WIN_SIZE);
    assign w_wr      = w_hit & ~we_n;
    assign w_wr_ctrl = w_wr & (w_off == C_OFF_CTRL);
    assign w_abort   = w_wr_ctrl & datao[7];
    assign w_start   = w_wr_ctrl & datao[0] & ~datao[7];
    assign w_stat_rd = w_hit & we_n & (w_off == C_OFF_STATUS);
    assign w_busy    = (state_q != S_IDLE);
    assign cnt_d     = cnt_q + 16'd1;

    assign rd_hit   = w_hit;
    assign data     = op_q;
    assign data_rdy = data_rdy_q;

`ifdef GAIN_IRQ_EN
    logic irq_en_q;
    logic irq_n_q;

    assign irq_en = irq_en_q;
    assign irq_n  = irq_n_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_n_q  <= 1'b1;
        end else begin
            if (w_wr_ctrl) begin
                irq_en_q <= datao[1];
            end
            irq_n_q <= ~(irq_en_q & (done_q | timeout_q));
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    always_comb begin
        rd_data = 8'h00;
        if (w_hit) begin
            case (w_off[2:0])
                3'd0:    rd_data = op_q[7:0];
                3'd1:    rd_data = op_q[15:8];
                3'd2:    rd_data = res_q[7:0];
                3'd3:    rd_data = res_q[15:8];
                3'd4:    rd_data = {6'b0, irq_en, w_busy};
                3'd5:    rd_data = {5'b0, timeout_q, done_q, w_busy};
                default: rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 16'h0000;
            res_q      <= 16'h0000;
            cnt_q      <= 16'h0000;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            data_rdy_q <= 1'b0;
        end else begin
            // Status read clears first so that a set in the same cycle below wins.
            if (w_stat_rd) begin
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
            end

            if (w_wr && !w_busy) begin
                if (w_off == C_OFF_OP_LO) begin
                    op_q[7:0] <= datao;
                end
                if (w_off == C_OFF_OP_HI) begin
                    op_q[15:8] <= datao;
                end
            end

            if (w_abort) begin
                state_q    <= S_IDLE;
                data_rdy_q <= 1'b0;
                cnt_q      <= 16'h0000;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // A product still flagged valid would be stale for a new operand.
                        if (w_start && !result_rdy) begin
                            state_q    <= S_WAIT;
                            data_rdy_q <= 1'b1;
                            cnt_q      <= 16'h0000;
                        end
                    end
                    S_WAIT: begin
                        cnt_q <= cnt_d;
                        if (result_rdy) begin
                            state_q <= S_CAPTURE;
                        end else if (cnt_d == C_TIMEOUT) begin
                            state_q    <= S_DRAIN;
                            data_rdy_q <= 1'b0;
                            timeout_q  <= 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        res_q      <= result;
                        data_rdy_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (!result_rdy) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q    <= S_IDLE;
                        data_rdy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/gain_mul_ctrl.md
GAIN_MUL_CTRL -- requirements
Module: gain_mul_ctrl

Interface
REQ-001 Parameter: BASE, default 16'h1FF0, base address of the 6-byte register window (BASE+0..BASE+5).
REQ-002 Parameter: TIMEOUT, default 255, maximum WAIT cycles, 1..65535.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 addr  in  16  CPU address bus.
REQ-006 datao  in  8  CPU write data.
REQ-007 we_n  in  1  CPU write strobe; 0=write, 1=read.
REQ-008 rd_data  out  8  read data for the addressed register; combinational; 8'h00 outside the window.
REQ-009 rd_hit  out  1  combinational; 1 when addr is in BASE..BASE+5.
REQ-010 data  out  16  operand to the multiplier.
REQ-011 data_rdy  out  1  operand-valid flag to the multiplier.
REQ-012 result  in  16  product from the multiplier.
REQ-013 result_rdy  in  1  product-valid flag from the multiplier.
REQ-014 irq_n  out  1  active-low interrupt request; present only with GAIN_IRQ_EN.

Function
REQ-015 Register map: BASE+0 OP_LO (RW); BASE+1 OP_HI (RW); BASE+2 RES_LO (RO); BASE+3 RES_HI (RO); BASE+4 CTRL (W: bit0 start, bit1 irq_en, bit7 abort; reads {6'b0, irq_en, busy}); BASE+5 STATUS (R: bit0 busy, bit1 done, bit2 timeout, others 0).
REQ-016 A write occurs on every rising edge with we_n=0 and rd_hit=1; writes to RO addresses are ignored.
REQ-017 While busy, OP_LO and OP_HI writes are ignored; data = {OP_HI, OP_LO} at all times.
REQ-018 FSM states: IDLE, WAIT, CAPTURE, DRAIN; busy=1 in every state except IDLE.
REQ-019 IDLE: a start write (CTRL bit0=1, bit7=0) moves the FSM to WAIT and sets data_rdy=1 on the next edge. Latency: start write at edge N gives data_rdy=1 after edge N.
REQ-020 IDLE with result_rdy=1 on a start write: the start is ignored. A stale product is never accepted.
REQ-021 WAIT: data_rdy held at 1; the cycle counter increments each cycle. When result_rdy=1, go to CAPTURE.
REQ-022 CAPTURE (1 cycle): latch result into RES_HI/RES_LO, data_rdy=0, done=1, then go to DRAIN.
REQ-023 DRAIN: hold until result_rdy=0, then go to IDLE.
REQ-024 WAIT timeout: when the counter reaches TIMEOUT with result_rdy=0, set data_rdy=0 and timeout=1, then go to DRAIN. RES is unchanged.
REQ-025 result_rdy=1 in the same cycle as counter==TIMEOUT: the product wins, so the FSM goes to CAPTURE and timeout stays 0.
REQ-026 Start while busy is ignored. Abort (CTRL bit7=1) in any state: next state IDLE, data_rdy=0, counter cleared, done and timeout unchanged. Abort has priority over start in the same write.
REQ-027 A read of STATUS (we_n=1, addr=BASE+5) clears done and timeout at that edge. If a set event occurs in the same cycle, the set wins.
REQ-028 The counter is 16 bits and is cleared on entering WAIT. It never wraps, because the timeout check fires first.

Reset
REQ-029 On rst=1 at an edge: FSM=IDLE; OP, RES and counter = 0; done, timeout and irq_en = 0; data=16'h0000; data_rdy=0; irq_n=1.
REQ-030 rst mid-operation drops data_rdy on the same edge and discards the in-flight operation.
REQ-031 rst has priority over every bus write in the same cycle.

Configuration
REQ-032 Macro GAIN_IRQ_EN defined: irq_n is a registered output equal to ~(irq_en & (done | timeout)), and CTRL bit1 is stored.
REQ-033 Macro GAIN_IRQ_EN undefined: the irq_n port, irq_en storage and IRQ logic are absent; CTRL bit1 is ignored and reads 0.

Verification
REQ-034 Write OP=16'h0203, start; model returns 16'h0406 with result_rdy 3 cycles after data_rdy. Required: data_rdy rises 1 cycle after start; RES=16'h0406; STATUS=8'h02 after DRAIN.
REQ-035 Set TIMEOUT=8; start; hold result_rdy=0. Required: data_rdy=0 after 8 WAIT cycles; STATUS=8'h05 while in DRAIN; RES unchanged.
REQ-036 Write OP_LO=8'hFF during WAIT, then write start again. Required: data unchanged; no restart; a single CAPTURE occurs.
REQ-037 Write CTRL=8'h81 during WAIT. Required: IDLE next cycle; data_rdy=0; done=0.
REQ-038 Assert rst in CAPTURE. Required: all outputs at reset values next cycle; a later start operates normally.
REQ-039 With GAIN_IRQ_EN, set irq_en, then complete an operation. Required: irq_n=0 one cycle after done sets; a STATUS read returns 8'h02 and irq_n=1 on the next cycle.
